// File: rtl/cc_counter_udx_pkg.sv
// Shared definitions for the cc_counter_udx up/down counter:
// terminal-behaviour modes and the MAX helper.
package cc_counter_udx_pkg;

  localparam int unsigned CC_MODE_WRAP    = 0;
  localparam int unsigned CC_MODE_SAT     = 1;
  localparam int unsigned CC_MODE_ONESHOT = 2;

  // Largest count value: full binary range, or MODULUS-1
  function automatic longint unsigned cc_max(
    input int unsigned       w,
    input longint unsigned   m
  );
    if (m == 64'd0) return (64'd1 << w) - 64'd1;
    return m - 64'd1;
  endfunction

endpackage

// File: rtl/cc_counter_udx.sv
// Loadable up/down counter with configurable width, modulus and
// terminal behaviour (wrap, saturate, one-shot) plus a cascade output.
module cc_counter_udx
  import cc_counter_udx_pkg::*;
#(
  parameter int unsigned     WIDTH       = 16,
  parameter longint unsigned MODULUS     = 0,
  parameter int unsigned     MODE        = CC_MODE_WRAP,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             WRAP,
  output logic             DONE
);

  localparam longint unsigned MAX64 = cc_max(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] MAXV = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV =
    (RESET_VALUE > MAX64) ? MAXV : RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("cc_counter_udx: WIDTH must be 2..32");
    end
    if (MODULUS == 64'd1 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("cc_counter_udx: MODULUS must be 0 or 2..2^WIDTH");
    end
    if (MODE > CC_MODE_ONESHOT) begin : g_bad_mode
      $error("cc_counter_udx: MODE must be 0..2");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_done;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_wrap_nx;
  logic             w_done_nx;
  logic [WIDTH-1:0] w_term;
  logic             w_tc;
  logic             w_cnt;

  assign w_term = UP ? MAXV : '0;
  assign w_tc   = (r_q == w_term);
  assign w_cnt  = CE & ~r_done;

  always_comb begin
    w_q_nx    = r_q;
    w_done_nx = r_done;
    w_wrap_nx = 1'b0;
    if (L) begin
      w_q_nx    = (D > MAXV) ? MAXV : D;
      w_done_nx = 1'b0;
    end else if (w_cnt && !w_tc) begin
      w_q_nx = UP ? r_q + ONE : r_q - ONE;
    end else if (w_cnt) begin
      // At terminal: only wrap mode moves; one-shot latches DONE
      if (MODE == CC_MODE_WRAP) begin
        w_q_nx    = UP ? '0 : MAXV;
        w_wrap_nx = 1'b1;
      end else if (MODE == CC_MODE_ONESHOT) begin
        w_done_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q    <= RSTV;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nx;
      r_wrap <= w_wrap_nx;
      r_done <= w_done_nx;
    end
  end

  assign Q    = r_q;
  assign TC   = w_tc;
  assign CEO  = w_tc & CE & ~r_done;
  assign WRAP = r_wrap;
  assign DONE = r_done;

endmodule

// File: tb/tb_cc_counter_udx.sv
// Scoreboard bench for cc_counter_udx: several configurations share
// one stimulus stream and are checked against an arithmetic model.
module tb_cc_counter_udx;

  localparam int NI = 6;

  typedef struct packed {
    logic [NI-1:0][7:0] q;
    logic [NI-1:0]      tc;
    logic [NI-1:0]      ceo;
    logic [NI-1:0]      wrap;
    logic [NI-1:0]      done;
    logic [7:0]         cnt;
    logic               hw;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       ce;
  logic       l;
  logic       up;
  logic [7:0] d;

  // inst: 0 full/wrap, 1 mod10/wrap rv3, 2 full/sat,
  //       3 mod10/oneshot rv12->9, 4 w2/wrap, 5 mod2/wrap rv1
  int pmax [NI] = '{255, 9, 255, 9, 3, 1};
  int pmode[NI] = '{0, 0, 1, 2, 0, 0};
  int prv  [NI] = '{0, 3, 0, 9, 0, 1};
  int pdm  [NI] = '{255, 255, 255, 255, 3, 255};

  int mq   [NI];
  int mwrap[NI];
  int mdone[NI];
  int mcnt;
  int mhw;

  exp_t sbq[$];
  exp_t me;
  int   n_chk;
  int   n_err;

  wire [7:0] q0, q1, q2, q3, q5;
  wire [1:0] q4;
  wire [NI-1:0] w_tc, w_ceo, w_wrap, w_done;
  wire [3:0] lq, hq;
  wire       lceo, hceo, ltc, htc, lwr, hwr, ldn, hdn;
  logic [NI-1:0][7:0] a_q;

  always_comb begin
    a_q[0] = q0;
    a_q[1] = q1;
    a_q[2] = q2;
    a_q[3] = q3;
    a_q[4] = {6'd0, q4};
    a_q[5] = q5;
  end

  cc_counter_udx #(.WIDTH(8), .MODULUS(0), .MODE(0), .RESET_VALUE(0)) u0 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d), .UP(up), .Q(q0),
    .TC(w_tc[0]), .CEO(w_ceo[0]), .WRAP(w_wrap[0]), .DONE(w_done[0]));
  cc_counter_udx #(.WIDTH(8), .MODULUS(10), .MODE(0), .RESET_VALUE(3)) u1 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d), .UP(up), .Q(q1),
    .TC(w_tc[1]), .CEO(w_ceo[1]), .WRAP(w_wrap[1]), .DONE(w_done[1]));
  cc_counter_udx #(.WIDTH(8), .MODULUS(0), .MODE(1), .RESET_VALUE(0)) u2 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d), .UP(up), .Q(q2),
    .TC(w_tc[2]), .CEO(w_ceo[2]), .WRAP(w_wrap[2]), .DONE(w_done[2]));
  cc_counter_udx #(.WIDTH(8), .MODULUS(10), .MODE(2), .RESET_VALUE(12)) u3 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d), .UP(up), .Q(q3),
    .TC(w_tc[3]), .CEO(w_ceo[3]), .WRAP(w_wrap[3]), .DONE(w_done[3]));
  cc_counter_udx #(.WIDTH(2), .MODULUS(0), .MODE(0), .RESET_VALUE(0)) u4 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d[1:0]), .UP(up), .Q(q4),
    .TC(w_tc[4]), .CEO(w_ceo[4]), .WRAP(w_wrap[4]), .DONE(w_done[4]));
  cc_counter_udx #(.WIDTH(8), .MODULUS(2), .MODE(0), .RESET_VALUE(1)) u5 (
    .C(clk), .CLR(clr), .CE(ce), .L(l), .D(d), .UP(up), .Q(q5),
    .TC(w_tc[5]), .CEO(w_ceo[5]), .WRAP(w_wrap[5]), .DONE(w_done[5]));

  cc_counter_udx #(.WIDTH(4)) u_lo (
    .C(clk), .CLR(clr), .CE(ce), .L(1'b0), .D(4'h0), .UP(1'b1), .Q(lq),
    .TC(ltc), .CEO(lceo), .WRAP(lwr), .DONE(ldn));
  cc_counter_udx #(.WIDTH(4)) u_hi (
    .C(clk), .CLR(clr), .CE(lceo), .L(1'b0), .D(4'h0), .UP(1'b1), .Q(hq),
    .TC(htc), .CEO(hceo), .WRAP(hwr), .DONE(hdn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d",
               nm, k, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, record what the
  // monitor should see at the following falling edge, then advance
  // the model across the upcoming rising edge.
  task automatic step(input logic l_i, input logic ce_i, input logic up_i,
                      input logic [7:0] d_i, input logic clr_i);
    exp_t e;
    int v, n, term;
    @(posedge clk);
    #2;
    clr = clr_i; l = l_i; ce = ce_i; up = up_i; d = d_i;
    if (clr_i) begin
      for (int k = 0; k < NI; k++) begin
        mq[k] = prv[k]; mwrap[k] = 0; mdone[k] = 0;
      end
      mcnt = 0; mhw = 0;
    end
    e = '0;
    for (int k = 0; k < NI; k++) begin
      term = up_i ? pmax[k] : 0;
      e.q[k]    = 8'(mq[k]);
      e.tc[k]   = (mq[k] == term);
      e.ceo[k]  = (mq[k] == term) && ce_i && (mdone[k] == 0);
      e.wrap[k] = mwrap[k][0];
      e.done[k] = mdone[k][0];
    end
    e.cnt = 8'(mcnt);
    e.hw  = mhw[0];
    sbq.push_back(e);
    if (!clr_i) begin
      for (int k = 0; k < NI; k++) begin
        n = pmax[k] + 1;
        term = up_i ? pmax[k] : 0;
        mwrap[k] = 0;
        if (l_i) begin
          v = int'(d_i) & pdm[k];
          mq[k] = (v > pmax[k]) ? pmax[k] : v;
          mdone[k] = 0;
        end else if (ce_i && mdone[k] == 0) begin
          if (pmode[k] == 0) begin
            mwrap[k] = (mq[k] == term) ? 1 : 0;
            mq[k] = up_i ? (mq[k] + 1) % n : (mq[k] + n - 1) % n;
          end else begin
            if (pmode[k] == 2 && mq[k] == term) mdone[k] = 1;
            if (up_i) mq[k] = (mq[k] < pmax[k]) ? mq[k] + 1 : pmax[k];
            else      mq[k] = (mq[k] > 0) ? mq[k] - 1 : 0;
          end
        end
      end
      mhw  = (ce_i && mcnt == 255) ? 1 : 0;
      mcnt = ce_i ? (mcnt + 1) % 256 : mcnt;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      for (int k = 0; k < NI; k++) begin
        chk("Q",    k, int'(a_q[k]),     int'(me.q[k]));
        chk("TC",   k, int'(w_tc[k]),    int'(me.tc[k]));
        chk("CEO",  k, int'(w_ceo[k]),   int'(me.ceo[k]));
        chk("WRAP", k, int'(w_wrap[k]),  int'(me.wrap[k]));
        chk("DONE", k, int'(w_done[k]),  int'(me.done[k]));
      end
      chk("CASCADE_Q", 6, int'({hq, lq}), int'(me.cnt));
      chk("CASCADE_HWRAP", 6, int'(hwr), int'(me.hw));
    end
  end

  initial begin
    logic r_up;
    n_chk = 0; n_err = 0;
    clr = 1'b1; l = 1'b0; ce = 1'b0; up = 1'b1; d = 8'd0;
    mcnt = 0; mhw = 0;
    for (int k = 0; k < NI; k++) begin
      mq[k] = prv[k]; mwrap[k] = 0; mdone[k] = 0;
    end
    repeat (2) step(1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
    // full-range count up through the wrap, cascade past 256
    repeat (262) step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    // mod-10 down count with wrap, then clamped load
    step(1'b1, 1'b0, 1'b0, 8'd3, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd12, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    // saturation at the top, then reverse direction
    step(1'b1, 1'b0, 1'b1, 8'd254, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    // one-shot down to zero, stuck, then reload
    step(1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    // load beats count enable, then a mid-count clear held over edges
    step(1'b1, 1'b1, 1'b1, 8'd7, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    // randomized traffic
    r_up = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_up = ~r_up;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, r_up,
           8'($urandom_range(0, 255)), $urandom_range(0, 149) == 0);
    end
    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
